// File: rtl/memory_controller.sv
// Single-port memory controller.
// Accepts read/write requests over a valid/ready handshake and sequences them
// onto a shared bidirectional memory bus. Reads return through a held
// response channel. Completed reads and writes are counted with saturating
// counters.
module memory_controller #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              wr_ack,
  output logic              mem_instruction,
  output logic [ADDR_W-1:0] mem_address,
  inout  wire  [DATA_W-1:0] mem_data,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] WRITE      = 3'd1;
  localparam logic [2:0] RD_ISSUE   = 3'd2;
  localparam logic [2:0] RD_CAPTURE = 3'd3;
  localparam logic [2:0] RESP       = 3'd4;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [DATA_W-1:0] wdata_q;
  logic              accept;

  // Reset is folded into req_ready so nothing is offered while reset is held.
  assign req_ready       = (state == IDLE) && reset_n;
  assign accept          = req_valid && req_ready;
  assign rsp_valid       = (state == RESP);
  // The memory writes whenever this is low, so only WRITE may drop it.
  assign mem_instruction = (state != WRITE);
  // The controller drives the bus only while the memory is in write mode.
  assign mem_data        = (state == WRITE) ? wdata_q : 'z;

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (accept) state_nxt = req_write ? WRITE : RD_ISSUE;
      WRITE:      state_nxt = IDLE;
      RD_ISSUE:   state_nxt = RD_CAPTURE;
      RD_CAPTURE: state_nxt = RESP;
      RESP:       if (rsp_ready) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Request latch: address goes straight to the memory address register,
  // which therefore holds its last value outside of new acceptances.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_address <= '0;
      wdata_q     <= '0;
    end else if (accept) begin
      mem_address <= req_addr;
      wdata_q     <= req_wdata;
    end
  end

  // Read data capture and write acknowledge pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp_data <= '0;
      wr_ack   <= 1'b0;
    end else begin
      wr_ack <= (state == WRITE);
      if (state == RD_CAPTURE) rsp_data <= mem_data;
    end
  end

  // Saturating completion counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if ((state == RESP) && rsp_ready && (rd_count != '1)) rd_count <= rd_count + 16'd1;
      if ((state == WRITE) && (wr_count != '1))             wr_count <= wr_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_memory_controller.sv
// Directed bench for memory_controller with a behavioural single-port memory
// sampling on every rising edge.
module tb_memory_controller;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_write;
  logic [11:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic        wr_ack, mem_instruction;
  logic [11:0] mem_address;
  wire  [15:0] mem_data;
  logic [15:0] rd_count, wr_count;

  int checks   = 0;
  int failures = 0;
  int wr_cycles = 0;
  logic [15:0] exp_wr = '0;
  logic [15:0] exp_rd = '0;

  always #5 clock = ~clock;

  memory_controller #(.ADDR_W(12), .DATA_W(16)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .wr_ack(wr_ack), .mem_instruction(mem_instruction),
    .mem_address(mem_address), .mem_data(mem_data),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  // Memory model: write when instruction=0, load read register when 1.
  logic [15:0] mem [0:4095];
  logic [15:0] rd_reg = '0;
  initial for (int i = 0; i < 4096; i++) mem[i] = '0;
  always @(posedge clock) begin
    if (!mem_instruction) mem[mem_address] <= mem_data;
    else                  rd_reg <= mem[mem_address];
  end
  assign mem_data = mem_instruction ? rd_reg : 'z;

  // Count bus write cycles.
  always @(negedge clock) if (!mem_instruction) wr_cycles++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_sum();
    logic [31:0] s = '0;
    for (int i = 0; i < 4096; i++) s = s + {16'd0, mem[i]} * 32'(i + 1);
    return s;
  endfunction

  // Offer a request and return at the negedge of the first cycle after acceptance.
  task automatic issue(input logic w, input logic [11:0] a, input logic [15:0] d);
    int n = 0;
    while (!req_ready && n < 10) begin @(negedge clock); n++; end
    if (!req_ready) chk("req_ready_timeout", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    @(posedge clock); #1;
    req_valid = 1'b0;
    req_write = 1'($urandom); req_addr = 12'($urandom); req_wdata = 16'($urandom);
    @(negedge clock);
  endtask

  task automatic do_write(input logic [11:0] a, input logic [15:0] d);
    issue(1'b1, a, d);
    chk("wr_mem_instr", 32'(mem_instruction), 32'd0);
    chk("wr_mem_addr", 32'(mem_address), 32'(a));
    chk("wr_mem_data", 32'(mem_data), 32'(d));
    chk("wr_ack_early", 32'(wr_ack), 32'd0);
    @(negedge clock);
    if (exp_wr != 16'hFFFF) exp_wr = exp_wr + 16'd1;
    chk("wr_ack", 32'(wr_ack), 32'd1);
    chk("wr_idle_instr", 32'(mem_instruction), 32'd1);
    chk("wr_committed", 32'(mem[a]), 32'(d));
    chk("wr_count", 32'(wr_count), 32'(exp_wr));
    chk("wr_req_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic do_read(input logic [11:0] a, input logic [15:0] exp, input int stall);
    rsp_ready = (stall == 0);
    issue(1'b0, a, 16'd0);
    chk("rd_issue_instr", 32'(mem_instruction), 32'd1);
    chk("rd_issue_addr", 32'(mem_address), 32'(a));
    chk("rd_issue_valid", 32'(rsp_valid), 32'd0);
    chk("rd_busy_ready", 32'(req_ready), 32'd0);
    @(negedge clock);
    chk("rd_capture_valid", 32'(rsp_valid), 32'd0);
    @(negedge clock);
    chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rd_rsp_data", 32'(rsp_data), 32'(exp));
    for (int k = 0; k < stall; k++) begin
      @(negedge clock);
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_data", 32'(rsp_data), 32'(exp));
      chk("stall_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    if (exp_rd != 16'hFFFF) exp_rd = exp_rd + 16'd1;
    chk("rd_done_valid", 32'(rsp_valid), 32'd0);
    chk("rd_done_ready", 32'(req_ready), 32'd1);
    chk("rd_count", 32'(rd_count), 32'(exp_rd));
  endtask

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [15:0] data;  // write data, or expected read data
  } op_t;

  op_t ops [11];

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] sum0;
    int wc0;

    ops[0]  = '{1'b1, 12'h123, 16'd43};
    ops[1]  = '{1'b1, 12'h1A1, 16'd24};
    ops[2]  = '{1'b0, 12'h123, 16'd43};
    ops[3]  = '{1'b0, 12'h1A1, 16'd24};
    ops[4]  = '{1'b1, 12'h0FF, 16'hFFFF};
    ops[5]  = '{1'b1, 12'h000, 16'h1234};
    ops[6]  = '{1'b0, 12'h0FF, 16'hFFFF};
    ops[7]  = '{1'b0, 12'h000, 16'h1234};
    ops[8]  = '{1'b0, 12'h7FF, 16'h0000};
    ops[9]  = '{1'b1, 12'hFFF, 16'hA5A5};
    ops[10] = '{1'b0, 12'hFFF, 16'hA5A5};

    reset_n = 1'b0; rsp_ready = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_mem_instr", 32'(mem_instruction), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_wr_ack", 32'(wr_ack), 32'd0);
    chk("rst_mem_addr", 32'(mem_address), 32'd0);
    chk("rst_counts", {rd_count, wr_count}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    // Write then read back one location.
    do_write(12'h1A1, 16'd81);
    do_read(12'h1A1, 16'd81, 0);
    chk("s1_counts", {rd_count, wr_count}, {16'd1, 16'd1});

    // Table of back-to-back operations.
    wc0 = wr_cycles;
    foreach (ops[i]) begin
      if (ops[i].wr) do_write(ops[i].addr, ops[i].data);
      else           do_read(ops[i].addr, ops[i].data, 0);
      if (i == 3) chk("s2_write_cycles", 32'(wr_cycles - wc0), 32'd2);
    end

    // Stalled response.
    do_read(12'h123, 16'd43, 5);

    // Idle with noise on the request fields.
    sum0 = mem_sum();
    wc0  = wr_cycles;
    for (int k = 0; k < 20; k++) begin
      req_valid = 1'b0; req_write = 1'($urandom);
      req_addr = 12'($urandom); req_wdata = 16'($urandom);
      @(negedge clock);
      chk("idle_instr", 32'(mem_instruction), 32'd1);
    end
    chk("idle_mem", mem_sum(), sum0);
    chk("idle_wr_cycles", 32'(wr_cycles), 32'(wc0));
    chk("idle_counts", {rd_count, wr_count}, {exp_rd, exp_wr});

    // Reset landing in WRITE.
    issue(1'b1, 12'h0AA, 16'd35);
    chk("mid_wr_instr", 32'(mem_instruction), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_instr", 32'(mem_instruction), 32'd1);
    chk("mid_rst_bus", 32'(mem_data), 32'(rd_reg));
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_addr", 32'(mem_address), 32'd0);
    chk("mid_rst_rsp", {15'd0, rsp_valid, rsp_data}, 32'd0);
    chk("mid_rst_counts", {rd_count, wr_count}, 32'd0);
    @(negedge clock);
    chk("mid_rst_wr_ack", 32'(wr_ack), 32'd0);
    reset_n = 1'b1;
    exp_wr = '0; exp_rd = '0;
    #1;
    chk("mid_rst_mem", 32'(mem[12'h0AA]), 32'd0);
    do_read(12'h0AA, 16'd0, 0);

    // Write counter saturation.
    force dut.wr_count = 16'hFFFE;
    #1;
    release dut.wr_count;
    exp_wr = 16'hFFFE;
    chk("sat_preload", 32'(wr_count), 32'(exp_wr));
    do_write(12'h010, 16'd1);
    do_write(12'h011, 16'd2);
    do_write(12'h012, 16'd3);
    chk("sat_final", 32'(wr_count), 32'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_controller.md
MEMORY_CONTROLLER -- requirements
Module: memory_controller

Interface
REQ-001 The block SHALL have the following parameters:
- ADDR_W, default 12, memory address width.
- DATA_W, default 16, memory word width.

REQ-002 The block SHALL have the following ports, one per line as name, direction, width, meaning:
- clock, in, 1, single clock; all state updates on rising edge.
- reset_n, in, 1, reset, asynchronous assert, active-low.
- req_valid, in, 1, request offered.
- req_ready, out, 1, controller can accept a request.
- req_write, in, 1, 1 = write, 0 = read.
- req_addr, in, ADDR_W, request address.
- req_wdata, in, DATA_W, write data.
- rsp_valid, out, 1, read data available.
- rsp_ready, in, 1, consumer takes read data.
- rsp_data, out, DATA_W, read data.
- wr_ack, out, 1, one-cycle pulse: write committed.
- mem_instruction, out, 1, to memory; 1 = read, 0 = write.
- mem_address, out, ADDR_W, to memory address.
- mem_data, inout, DATA_W, shared bidirectional memory bus.
- rd_count, out, 16, completed reads, saturating at 16'hFFFF.
- wr_count, out, 16, completed writes, saturating at 16'hFFFF.

Function
REQ-003 The memory SHALL sample on every rising clock edge:
- It writes mem_data to mem_address whenever mem_instruction=0.
- It loads its read register whenever mem_instruction=1, and drives mem_data combinationally while mem_instruction=1.
REQ-004 Because of REQ-003, mem_instruction SHALL be 1 in every state except WRITE, so no unintended write occurs.
REQ-005 mem_data SHALL be driven by the controller (registered write data) only while mem_instruction=0, and SHALL be high-impedance otherwise, so no bus contention is possible.
REQ-006 The FSM SHALL have exactly the states IDLE, WRITE, RD_ISSUE, RD_CAPTURE and RESP, all registered.
REQ-007 req_ready SHALL be 1 only in IDLE.
REQ-008 A request SHALL be accepted on an edge with req_valid && req_ready. On acceptance, req_addr, req_write and req_wdata are latched; inputs in other cycles are ignored.
REQ-009 On an accepted write, IDLE SHALL go to WRITE. In WRITE:
- mem_instruction=0, mem_address = latched address, mem_data = latched data.
- On the next edge the memory commits the write, the FSM returns to IDLE, and wr_ack pulses high for the following cycle.
REQ-010 On an accepted read, IDLE SHALL go to RD_ISSUE. In RD_ISSUE:
- mem_instruction=1, mem_address = latched address.
- The memory loads on the next edge.
REQ-011 In RD_CAPTURE, mem_data is valid from the memory, and on the next edge rsp_data SHALL capture mem_data and the FSM goes to RESP.
REQ-012 In RESP, rsp_valid=1 and rsp_data SHALL be held stable until an edge with rsp_ready=1, after which the FSM returns to IDLE.
REQ-013 Read latency SHALL be: rsp_valid asserted the 3rd cycle after the acceptance edge. If rsp_ready is held 1, the read occupies 3 cycles.
REQ-014 Write latency SHALL be: wr_ack in the 2nd cycle after acceptance. Back-to-back writes sustain one write per 2 cycles.
REQ-015 mem_address SHALL hold its last value in IDLE and RESP.
REQ-016 rd_count SHALL increment on the RESP -> IDLE transition. wr_count SHALL increment on the WRITE -> IDLE transition. Both saturate at 16'hFFFF with no wrap.
REQ-017 req_valid deasserting while the FSM is busy SHALL have no effect. Changes on req_* while busy SHALL NOT alter the operation in flight.

Reset
REQ-018 reset_n=0 SHALL asynchronously force the following, regardless of the operation in progress:
- state=IDLE.
- mem_instruction=1, so the bus is released and no write occurs, including when reset lands in WRITE.
- mem_address=0.
- rsp_valid=0, rsp_data=0, wr_ack=0.
- rd_count=0, wr_count=0.
- req_ready=0 while reset_n=0.
REQ-019 After reset_n rises, req_ready SHALL be 1 from the first cycle, and the first request may be accepted on the next edge.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Write 16'd81 to 12'h1A1, then read 12'h1A1 with rsp_ready=1 -> wr_ack one cycle; rsp_valid 3rd cycle after read accept, rsp_data=16'd81; wr_count=1, rd_count=1.
- Write 16'd43 to 12'h123, 16'd24 to 12'h1A1, then read both -> rsp_data 16'd43 then 16'd24; mem_instruction=0 in exactly 2 cycles total.
- Read with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stable, req_ready=0 throughout; completes on first rsp_ready=1 edge.
- Assert reset_n=0 mid-WRITE (addr 12'h0AA, data 16'd35) -> mem_instruction=1 immediately, bus Z from controller; subsequent read of 12'h0AA does not return 16'd35.
- Idle for 20 cycles with random req_* and req_valid=0 -> mem_instruction stays 1, no memory contents change, counters unchanged.
- Preload wr_count to 16'hFFFE via 3 writes after force -> counter saturates at 16'hFFFF.
